// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 2-flop input synchronizer, mid-bit sampling,
// parity/framing/overrun reporting and a valid/ready output register. Build macro: RX_MAJORITY_VOTE_EN.
module uart_rx_param #(
   parameter int CLK_RATE    = 100000000,
   parameter int BAUD_RATE   = 19200,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 2,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] dout,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic                 parity_error,
   output logic                 framing_error,
   output logic                 overrun,
   output logic                 busy
);

   // state     | meaning
   // WAIT_HIGH | after reset, wait for a settled high line
   // IDLE      | line idle, waiting for a falling edge
   // START     | validate start bit at half a bit period
   // DATA      | sample DATA_BITS data bits, LSB first
   // PARITY    | sample parity bit
   // STOP      | sample STOP_BITS stop bits
   // DONE      | one cycle: deliver word or flag overrun

   localparam int BAUD_DIV = CLK_RATE / BAUD_RATE;
   localparam int HALF_DIV = BAUD_DIV / 2;
`ifdef RX_MAJORITY_VOTE_EN
   localparam int CNT_W = $clog2(BAUD_DIV + 1);
`else
   localparam int CNT_W = $clog2(BAUD_DIV);
`endif
   localparam int BIT_W = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] HALF_TGT = CNT_W'(HALF_DIV - 1);
   localparam logic [CNT_W-1:0] BAUD_TGT = CNT_W'(BAUD_DIV - 1);
`ifdef RX_MAJORITY_VOTE_EN
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(1);
`else
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(0);
`endif

   if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_rx_param: PARITY_MODE must be 0, 1 or 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
      $error("uart_rx_param: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_param: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {
      WAIT_HIGH, IDLE, START, DATA, PARITY, STOP, DONE
   } state_t;

   state_t               state;
   logic [1:0]           sync;
   logic                 rx_s;
   logic [CNT_W-1:0]     cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 frame_err;
   logic [CNT_W-1:0]     tgt;
   logic                 hit;
   logic                 bit_s;
   logic                 par_err;
`ifdef RX_MAJORITY_VOTE_EN
   logic                 v_a;
   logic                 v_b;
`endif

   assign rx_s = sync[1];

   always_comb begin
      tgt = (state == START) ? HALF_TGT : BAUD_TGT;
`ifdef RX_MAJORITY_VOTE_EN
      hit   = (cnt == tgt + CNT_W'(1));
      bit_s = (v_a & v_b) | (v_a & rx_s) | (v_b & rx_s);
`else
      hit   = (cnt == tgt);
      bit_s = rx_s;
`endif
   end

   always_comb begin
      par_err = 1'b0;
      if (PARITY_MODE == 1)
         par_err = ^shreg ^ par_bit;
      else if (PARITY_MODE == 2)
         par_err = ~(^shreg ^ par_bit);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= WAIT_HIGH;
         sync          <= 2'b11;
         cnt           <= '0;
         bit_cnt       <= '0;
         shreg         <= '0;
         par_bit       <= 1'b0;
         frame_err     <= 1'b0;
         dout          <= '0;
         dout_valid    <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
         busy          <= 1'b1;
`ifdef RX_MAJORITY_VOTE_EN
         v_a           <= 1'b1;
         v_b           <= 1'b1;
`endif
      end else begin
         sync <= {sync[0], rx_in};
         cnt  <= cnt + CNT_W'(1);
`ifdef RX_MAJORITY_VOTE_EN
         if (cnt == tgt - CNT_W'(1)) v_a <= rx_s;
         if (cnt == tgt)             v_b <= rx_s;
`endif
         if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
         end

         case (state)
            // The first two cycles after reset only show the synchronizer reset value.
            WAIT_HIGH: if (rx_s && cnt >= CNT_W'(2)) begin
               state <= IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
            IDLE: if (!rx_s) begin
               state     <= START;
               cnt       <= '0;
               bit_cnt   <= '0;
               frame_err <= 1'b0;
               busy      <= 1'b1;
            end
            START: if (hit) begin
               cnt <= RELOAD;
               if (bit_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= DATA;
               end
            end
            DATA: if (hit) begin
               shreg <= {bit_s, shreg[DATA_BITS-1:1]};
               cnt   <= RELOAD;
               if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                  bit_cnt <= '0;
                  state   <= (PARITY_MODE != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
            PARITY: if (hit) begin
               par_bit <= bit_s;
               cnt     <= RELOAD;
               state   <= STOP;
            end
            STOP: if (hit) begin
               if (!bit_s) frame_err <= 1'b1;
               cnt <= RELOAD;
               if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                  bit_cnt <= '0;
                  state   <= DONE;
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
            DONE: begin
               cnt       <= '0;
               bit_cnt   <= '0;
               frame_err <= 1'b0;
               if (!dout_valid || dout_ready) begin
                  dout          <= shreg;
                  parity_error  <= par_err;
                  framing_error <= frame_err;
                  dout_valid    <= 1'b1;
               end else begin
                  overrun <= 1'b1;
               end
               if (rx_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            default: begin
               state <= WAIT_HIGH;
               cnt   <= '0;
               busy  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8-bit odd-parity receiver and a 7-bit no-parity 2-stop receiver.
module tb_uart_rx_param;

   localparam int CLK_RATE = 1700000;
   localparam int BAUD_RATE = 100000;
   localparam int BAUD_DIV = CLK_RATE / BAUD_RATE;
   localparam int HALF_DIV = BAUD_DIV / 2;
`ifdef RX_MAJORITY_VOTE_EN
   localparam int FS_LIMIT = HALF_DIV + 4;
`else
   localparam int FS_LIMIT = HALF_DIV + 3;
`endif

   typedef struct packed {
      logic [8:0] data;
      logic       pe;
      logic       fe;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic rx_a, rx_b;
   logic ready_a, ready_b;
   logic [7:0] dout_a;
   logic [6:0] dout_b;
   logic valid_a, pe_a, fe_a, ovr_a, busy_a;
   logic valid_b, pe_b, fe_b, ovr_b, busy_b;

   int n_checks = 0;
   int n_fail = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   always #5 clk = ~clk;

   uart_rx_param #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8),
                   .PARITY_MODE(2), .STOP_BITS(1)) u_a (
      .clk(clk), .rst_n(rst_n), .rx_in(rx_a), .dout(dout_a), .dout_valid(valid_a),
      .dout_ready(ready_a), .parity_error(pe_a), .framing_error(fe_a), .overrun(ovr_a),
      .busy(busy_a));

   uart_rx_param #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE), .DATA_BITS(7),
                   .PARITY_MODE(0), .STOP_BITS(2)) u_b (
      .clk(clk), .rst_n(rst_n), .rx_in(rx_b), .dout(dout_b), .dout_valid(valid_b),
      .dout_ready(ready_b), .parity_error(pe_b), .framing_error(fe_b), .overrun(ovr_b),
      .busy(busy_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] frame_a(input logic [7:0] d, input logic p, input logic s);
      return {s, p, d, 1'b0};
   endfunction

   function automatic logic [9:0] frame_b(input logic [6:0] d, input logic s1, input logic s2);
      return {s2, s1, d, 1'b0};
   endfunction

   task automatic send_bits(input int inst, input logic [63:0] bits, input int n);
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         if (inst == 0) rx_a = bits[i]; else rx_b = bits[i];
         repeat (BAUD_DIV) @(posedge clk);
         #1;
      end
      if (inst == 0) rx_a = 1'b1; else rx_b = 1'b1;
   endtask

   task automatic get_word(input int inst, input logic exp_ovr);
      exp_t e;
      logic v;
      v = 1'b0;
      for (int i = 0; i < 6 * BAUD_DIV; i++) begin
         @(negedge clk);
         v = (inst == 0) ? valid_a : valid_b;
         if (v) break;
      end
      chk("dout_valid_rise", {31'd0, v}, 32'd1);
      if ((inst == 0 ? q_a.size() : q_b.size()) == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = (inst == 0) ? q_a.pop_front() : q_b.pop_front();
         if (inst == 0) begin
            chk("dout_a", {24'd0, dout_a}, {23'd0, e.data});
            chk("parity_error_a", {31'd0, pe_a}, {31'd0, e.pe});
            chk("framing_error_a", {31'd0, fe_a}, {31'd0, e.fe});
            chk("overrun_a", {31'd0, ovr_a}, {31'd0, exp_ovr});
         end else begin
            chk("dout_b", {25'd0, dout_b}, {23'd0, e.data});
            chk("parity_error_b", {31'd0, pe_b}, {31'd0, e.pe});
            chk("framing_error_b", {31'd0, fe_b}, {31'd0, e.fe});
            chk("overrun_b", {31'd0, ovr_b}, {31'd0, exp_ovr});
         end
      end
   endtask

   task automatic accept(input int inst);
      @(posedge clk); #1;
      if (inst == 0) ready_a = 1'b1; else ready_b = 1'b1;
      @(posedge clk); #1;
      ready_a = 1'b0;
      ready_b = 1'b0;
      @(negedge clk);
      if (inst == 0) begin
         chk("valid_after_xfer_a", {31'd0, valid_a}, 32'd0);
         chk("overrun_after_xfer_a", {31'd0, ovr_a}, 32'd0);
      end else begin
         chk("valid_after_xfer_b", {31'd0, valid_b}, 32'd0);
      end
   endtask

   initial begin
      int  n;
      logic seen;
      rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_dout", {24'd0, dout_a}, 32'd0);
      chk("rst_valid", {31'd0, valid_a}, 32'd0);
      chk("rst_flags", {29'd0, pe_a, fe_a, ovr_a}, 32'd0);
      chk("rst_busy", {31'd0, busy_a}, 32'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("idle_busy", {30'd0, busy_a, busy_b}, 32'd0);

      // good odd-parity frame, held until a one-cycle ready pulse
      q_a.push_back('{data: 9'h0A5, pe: 1'b0, fe: 1'b0});
      send_bits(0, {53'd0, frame_a(8'hA5, 1'b1, 1'b1)}, 11);
      repeat (5) @(negedge clk);
      get_word(0, 1'b0);
      accept(0);

      q_a.push_back('{data: 9'h0A5, pe: 1'b1, fe: 1'b0});
      send_bits(0, {53'd0, frame_a(8'hA5, 1'b0, 1'b1)}, 11);
      get_word(0, 1'b0);
      accept(0);

      q_a.push_back('{data: 9'h03C, pe: 1'b0, fe: 1'b1});
      send_bits(0, {53'd0, frame_a(8'h3C, 1'b1, 1'b0)}, 11);
      get_word(0, 1'b0);
      accept(0);
      repeat (2 * BAUD_DIV) @(posedge clk);
      @(negedge clk);
      chk("idle_after_ferr", {31'd0, busy_a}, 32'd0);
      q_a.push_back('{data: 9'h000, pe: 1'b0, fe: 1'b0});
      send_bits(0, {53'd0, frame_a(8'h00, 1'b1, 1'b1)}, 11);
      get_word(0, 1'b0);
      accept(0);

      // short low glitch: false start
      repeat (2 * BAUD_DIV) @(posedge clk);
      #1 rx_a = 1'b0;
      seen = 1'b0; n = 0;
      for (int i = 0; i < 4 * BAUD_DIV; i++) begin
         @(posedge clk); #1;
         if (i == 4) rx_a = 1'b1;
         if (busy_a) begin
            seen = 1'b1;
            n++;
         end else if (seen) begin
            break;
         end
      end
      chk("fs_busy_seen", {31'd0, seen}, 32'd1);
      chk("fs_busy_len_ok", {31'd0, (n <= FS_LIMIT && !busy_a)}, 32'd1);
      repeat (2 * BAUD_DIV) @(posedge clk);
      @(negedge clk);
      chk("fs_no_valid", {31'd0, valid_a}, 32'd0);

      // three back-to-back frames with the consumer stalled
      q_a.push_back('{data: 9'h011, pe: 1'b0, fe: 1'b0});
      send_bits(0, {31'd0, frame_a(8'h33, 1'b1, 1'b1), frame_a(8'h22, 1'b1, 1'b1),
                    frame_a(8'h11, 1'b1, 1'b1)}, 33);
      get_word(0, 1'b1);
      accept(0);

      // 7 data bits, no parity, 2 stop bits
      q_b.push_back('{data: 9'h055, pe: 1'b0, fe: 1'b0});
      send_bits(1, {54'd0, frame_b(7'h55, 1'b1, 1'b1)}, 10);
      get_word(1, 1'b0);
      accept(1);
      q_b.push_back('{data: 9'h055, pe: 1'b0, fe: 1'b1});
      send_bits(1, {54'd0, frame_b(7'h55, 1'b1, 1'b0)}, 10);
      get_word(1, 1'b0);
      accept(1);
      repeat (2 * BAUD_DIV) @(posedge clk);

      // reset in the middle of a frame with the line stuck low afterwards
      @(posedge clk); #1 rx_a = 1'b0;
      repeat (3 * BAUD_DIV) @(posedge clk);
      @(negedge clk);
      chk("busy_mid_frame", {31'd0, busy_a}, 32'd1);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (4 * BAUD_DIV) @(posedge clk);
      @(negedge clk);
      chk("wait_high_busy", {31'd0, busy_a}, 32'd1);
      chk("wait_high_no_valid", {31'd0, valid_a}, 32'd0);
      @(posedge clk); #1 rx_a = 1'b1;
      repeat (2 * BAUD_DIV) @(posedge clk);
      @(negedge clk);
      chk("released_idle", {31'd0, busy_a}, 32'd0);
      q_a.push_back('{data: 9'h07E, pe: 1'b0, fe: 1'b0});
      send_bits(0, {53'd0, frame_a(8'h7E, 1'b1, 1'b1)}, 11);
      get_word(0, 1'b0);
      accept(0);
      repeat (3 * BAUD_DIV) @(posedge clk);
      @(negedge clk);
      chk("no_spurious_strobe", {31'd0, valid_a}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
